col_drain_collector: RTL and testbench
======================================

Name: col_drain_collector

Overview:
- Sits directly below the last-row PE of one systolic column; consumes its drained partial sums (col_result qualified by gemm_valid2).
- Captures up to DEPTH signed 20-bit results into a local buffer, then replays them one per handshake, after arithmetic right shift and saturation to OUT_W bits, to the activation/writeback stage.
- Decouples the fixed-rate systolic drain from a back-pressured consumer.

Parameters:
- IN_W, 20, width of col_result (signed two's complement)
- DEPTH, 16, results captured per drain burst (power of two)
- OUT_W, 8, quantized output width (signed)
- SHIFT, 8, arithmetic right-shift applied before saturation

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous, active-high reset
- sync_reset  input  1  synchronous clear; same effect as rst, evaluated at the clock edge
- state  input  2  mode: 00 GEMM, 01 CNN, 10 DNN; captures are accepted only in GEMM
- in_valid  input  1  from PE gemm_valid2; in_data is valid while high
- in_data  input  IN_W  from PE col_result
- out_valid  output  1  out_data/out_idx valid
- out_ready  input  1  consumer accepts when high together with out_valid
- out_data  output  OUT_W  quantized result
- out_idx  output  log2(DEPTH)  buffer index of out_data
- busy  output  1  high in FILL or DRAIN
- overflow  output  1  sticky; a sample was dropped

Behaviour:
- Reset (rst high, or sync_reset at an edge): FSM to IDLE; wr_ptr, rd_ptr, count = 0; out_valid = 0, out_idx = 0, busy = 0, overflow = 0. Buffer contents are not cleared. rst is honoured mid-burst with no partial output.
- FSM states: IDLE, FILL, DRAIN (2-bit encoding in package).
- IDLE:
  - in_valid=1 and state==00: write buf[0] = in_data, wr_ptr = 1, go to FILL.
  - in_valid=1 with state!=00: ignored, no overflow.
- FILL:
  - Each cycle with in_valid=1: write buf[wr_ptr], then increment wr_ptr.
  - When the DEPTH-th sample is written (wr_ptr wraps to 0): count = DEPTH, go to DRAIN.
  - in_valid=0 in FILL: count = wr_ptr (1..DEPTH-1), go to DRAIN. This is the early-terminated burst.
- DRAIN:
  - out_valid = 1 (state decode, so it is high from the cycle after the transition edge).
  - out_idx = rd_ptr; out_data = quantize(buf[rd_ptr]), combinational from the buffer.
  - out_valid & out_ready: rd_ptr++.
  - On acceptance of index count-1: rd_ptr = 0, wr_ptr = 0, go to IDLE; out_valid is low the next cycle.
  - out_ready low: out_data and out_idx must hold stable.
  - in_valid=1 during DRAIN: sample dropped, overflow set (sticky until rst/sync_reset).
- Latency: the last capture edge moves the FSM to DRAIN; the first out_valid appears in the following cycle. Throughput is 1 result/cycle when out_ready stays high.
- quantize(x):
  - y = x >>> SHIFT, sign-extended.
  - If y > 2^(OUT_W-1)-1, output max; if y < -2^(OUT_W-1), output min; otherwise output y[OUT_W-1:0].
- busy = (FSM != IDLE).
- Simultaneous sync_reset and handshake: sync_reset wins; no pointer advance.

Optional Feature:
- Macro COL_DRAIN_RELU_EN.
- Defined: quantize clamps negative x to 0 before shift and saturation; output range is [0, 2^(OUT_W-1)-1].
- Undefined: signed saturation exactly as in Behaviour.
- Port list is unchanged in both builds.

Decomposition:
- Shared package holds:
  - mode constants MODE_GEMM=2'b00, MODE_CNN=2'b01, MODE_DNN=2'b10
  - FSM encodings S_IDLE, S_FILL, S_DRAIN
  - default widths IN_W=20, OUT_W=8
- One natural sub-module: col_quantize, purely combinational shift+saturate(+ReLU) parameterized by IN_W, OUT_W, SHIFT. The FSM and buffer stay in the top.

Test Plan:
- Full burst: state=00, in_valid high 16 cycles, in_data = 256*k (k=0..15), out_ready=1 → 16 outputs, out_data=k, out_idx=k, first out_valid one cycle after the 16th capture, then busy=0.
- Saturation: in_data=20'h7FFFF then 20'h80000, then in_valid low → count=2; out_data=127 then -128 (RELU_EN build: 127 then 0).
- Early termination with back-pressure: 3 samples 512, 768, 1024, then out_ready toggled 1,0,0,1,1 → outputs 2, 3, 4 with data/idx held during stalls.
- Overflow: in_valid pulsed during DRAIN → that sample is absent from the output, overflow=1 and stays high until sync_reset.
- Mode gating: state=01, in_valid high 5 cycles → FSM stays IDLE, out_valid never rises, overflow=0.
- Reset mid-operation: rst asserted asynchronously after 7 captures → out_valid, busy, out_idx and overflow are 0 immediately. A new 16-sample burst after release drains correctly from idx 0.

Source files
------------

// File: rtl/col_drain_collector_pkg.sv
`default_nettype none
// ============================================================================
// Module      : col_drain_collector_pkg
// Description : Shared constants for the column drain collector: operating
//               mode codes, FSM state encodings and default data widths.
// Revision    : 1.0 - initial release
// ============================================================================
package col_drain_collector_pkg;

  // Operating mode codes carried on the 'state' input
  localparam logic [1:0] MODE_GEMM = 2'b00;
  localparam logic [1:0] MODE_CNN  = 2'b01;
  localparam logic [1:0] MODE_DNN  = 2'b10;

  // Collector FSM encodings
  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_FILL  = 2'b01;
  localparam logic [1:0] S_DRAIN = 2'b10;

  // Default datapath widths
  localparam int DEF_IN_W  = 20;
  localparam int DEF_OUT_W = 8;

endpackage
`default_nettype wire

// File: rtl/col_drain_collector_if.sv
`default_nettype none
// ============================================================================
// Module      : col_drain_collector_if
// Description : Capture and replay handshake bundle of the column drain
//               collector.
//               in_valid/in_data   : drained partial sums from the last PE
//               out_valid/out_ready: replay handshake to the writeback stage
//               out_data/out_idx   : quantized result and its buffer index
//               Modport 'slave' is the collector, 'master' its environment.
// Revision    : 1.0 - initial release
// ============================================================================
interface col_drain_collector_if #(
  parameter int IN_W  = 20,
  parameter int OUT_W = 8,
  parameter int IDX_W = 4
);
  logic             in_valid;
  logic [IN_W-1:0]  in_data;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic [IDX_W-1:0] out_idx;

  modport master (
    output in_valid, in_data, out_ready,
    input  out_valid, out_data, out_idx
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output out_valid, out_data, out_idx
  );
endinterface
`default_nettype wire

// File: rtl/col_drain_collector_quantize.sv
`default_nettype none
// ============================================================================
// Module      : col_quantize
// Description : Combinational quantizer: arithmetic right shift by SHIFT then
//               signed saturation to OUT_W bits. With COL_DRAIN_RELU_EN
//               defined, negative inputs are clamped to zero first.
//               x : signed IN_W-bit input
//               y : signed OUT_W-bit quantized output
// Revision    : 1.0 - initial release
// ============================================================================
module col_quantize #(
  parameter int IN_W  = 20,
  parameter int OUT_W = 8,
  parameter int SHIFT = 8
) (
  input  logic [IN_W-1:0]  x,
  output logic [OUT_W-1:0] y
);

  // Saturation bounds expressed at input width so the compare is exact
  localparam logic signed [IN_W-1:0] C_MAX = IN_W'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [IN_W-1:0] C_MIN = ~C_MAX;

  logic signed [IN_W-1:0] w_x;
  logic signed [IN_W-1:0] w_sh;

`ifdef COL_DRAIN_RELU_EN
  assign w_x = x[IN_W-1] ? '0 : $signed(x);
`else
  assign w_x = $signed(x);
`endif

  assign w_sh = w_x >>> SHIFT;

  always_comb begin
    y = w_sh[OUT_W-1:0];
    if (w_sh > C_MAX) begin
      y = C_MAX[OUT_W-1:0];
    end else if (w_sh < C_MIN) begin
      y = C_MIN[OUT_W-1:0];
    end
  end

endmodule
`default_nettype wire

// File: rtl/col_drain_collector.sv
`default_nettype none
// ============================================================================
// Module      : col_drain_collector
// Description : Captures a burst of up to DEPTH drained partial sums from one
//               systolic column and replays them, quantized, over a
//               valid/ready handshake.
//               clk, rst (async, active high), sync_reset (sync clear)
//               state    : mode, captures accepted only in GEMM (2'b00)
//               bus      : capture and replay handshake (slave modport)
//               busy     : FSM in FILL or DRAIN
//               overflow : sticky, a sample arrived during DRAIN
//               Optional macro COL_DRAIN_RELU_EN enables ReLU in quantize.
// Revision    : 1.0 - initial release
// ============================================================================
module col_drain_collector
  import col_drain_collector_pkg::*;
#(
  parameter int IN_W  = DEF_IN_W,
  parameter int DEPTH = 16,
  parameter int OUT_W = DEF_OUT_W,
  parameter int SHIFT = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sync_reset,
  input  logic [1:0]           state,
  col_drain_collector_if.slave bus,
  output logic                 busy,
  output logic                 overflow
);

  localparam int IDX_W = $clog2(DEPTH);

  logic [1:0]       r_fsm;
  logic [IDX_W-1:0] r_wr_ptr;
  logic [IDX_W-1:0] r_rd_ptr;
  logic [IDX_W:0]   r_count;
  logic             r_overflow;
  logic [IN_W-1:0]  r_buf [DEPTH];

  logic w_gemm;
  logic w_capture;
  logic w_accept;
  logic w_last;

  assign w_gemm    = (state == MODE_GEMM);
  // In IDLE the write pointer is always 0, so one write port covers both states
  assign w_capture = bus.in_valid && !sync_reset &&
                     (((r_fsm == S_IDLE) && w_gemm) || (r_fsm == S_FILL));
  assign w_accept  = (r_fsm == S_DRAIN) && bus.out_ready;
  assign w_last    = ({1'b0, r_rd_ptr} == (r_count - (IDX_W+1)'(1)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fsm      <= S_IDLE;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else if (sync_reset) begin
      r_fsm      <= S_IDLE;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      case (r_fsm)
        S_IDLE: begin
          if (bus.in_valid && w_gemm) begin
            r_wr_ptr <= IDX_W'(1);
            r_fsm    <= S_FILL;
          end
        end
        S_FILL: begin
          if (bus.in_valid) begin
            r_wr_ptr <= r_wr_ptr + IDX_W'(1);
            if (r_wr_ptr == IDX_W'(DEPTH - 1)) begin
              r_count <= (IDX_W+1)'(DEPTH);
              r_fsm   <= S_DRAIN;
            end
          end else begin
            // Early-terminated burst: everything written so far is replayed
            r_count <= {1'b0, r_wr_ptr};
            r_fsm   <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (bus.in_valid) begin
            r_overflow <= 1'b1;
          end
          if (w_accept) begin
            if (w_last) begin
              r_rd_ptr <= '0;
              r_wr_ptr <= '0;
              r_fsm    <= S_IDLE;
            end else begin
              r_rd_ptr <= r_rd_ptr + IDX_W'(1);
            end
          end
        end
        default: r_fsm <= S_IDLE;
      endcase
    end
  end

  // Buffer contents survive reset; only the pointers are cleared
  always_ff @(posedge clk) begin
    if (w_capture) begin
      r_buf[r_wr_ptr] <= bus.in_data;
    end
  end

  col_quantize #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W),
    .SHIFT (SHIFT)
  ) u_quantize (
    .x (r_buf[r_rd_ptr]),
    .y (bus.out_data)
  );

  assign bus.out_valid = (r_fsm == S_DRAIN);
  assign bus.out_idx   = r_rd_ptr;
  assign busy          = (r_fsm != S_IDLE);
  assign overflow      = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_col_drain_collector.sv
`default_nettype none
// ============================================================================
// Module      : tb_col_drain_collector
// Description : Directed self-checking bench for col_drain_collector.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_col_drain_collector;

  logic       clk = 1'b0;
  logic       rst;
  logic       sync_reset;
  logic [1:0] mode;
  logic       busy;
  logic       overflow;
  int         checks = 0;
  int         errors = 0;

  col_drain_collector_if #(.IN_W(20), .OUT_W(8), .IDX_W(4)) bus ();

  col_drain_collector #(
    .IN_W  (20),
    .DEPTH (16),
    .OUT_W (8),
    .SHIFT (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .sync_reset (sync_reset),
    .state      (mode),
    .bus        (bus),
    .busy       (busy),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; sync_reset = 1'b0; mode = 2'b00;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
    tick(); tick();
    checks++;
    if ({bus.out_valid, busy, overflow, bus.out_idx} !== 7'b0) begin
      errors++;
      $display("FAIL reset valid/busy/ovf/idx got %b exp 0000000",
               {bus.out_valid, busy, overflow, bus.out_idx});
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_full_burst();
    mode = 2'b00; bus.out_ready = 1'b0;
    for (int k = 0; k < 16; k++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 20'(256 * k);
      if (k == 15) begin
        checks++;
        if ({bus.out_valid, busy} !== 2'b01) begin
          errors++;
          $display("FAIL full_fill valid/busy got %b exp 01", {bus.out_valid, busy});
        end
      end
      tick();
    end
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      checks++;
      if ({bus.out_valid, bus.out_data, bus.out_idx} !== {1'b1, 8'(k), 4'(k)}) begin
        errors++;
        $display("FAIL full_out k=%0d valid=%b data=%0d idx=%0d exp valid=1 data=%0d idx=%0d",
                 k, bus.out_valid, bus.out_data, bus.out_idx, k, k);
      end
      tick();
    end
    checks++;
    if ({bus.out_valid, busy} !== 2'b00) begin
      errors++;
      $display("FAIL full_end valid/busy got %b exp 00", {bus.out_valid, busy});
    end
  endtask

  task automatic test_saturation();
    logic [7:0] exp_neg;
`ifdef COL_DRAIN_RELU_EN
    exp_neg = 8'h00;
`else
    exp_neg = 8'h80;
`endif
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1; bus.in_data = 20'h7FFFF; tick();
    bus.in_data = 20'h80000; tick();
    bus.in_valid = 1'b0; tick();
    bus.out_ready = 1'b1;
    checks++;
    if ({bus.out_valid, bus.out_data, bus.out_idx} !== {1'b1, 8'h7F, 4'd0}) begin
      errors++;
      $display("FAIL sat_max valid=%b data=%h idx=%0d exp 1 7f 0",
               bus.out_valid, bus.out_data, bus.out_idx);
    end
    tick();
    checks++;
    if ({bus.out_valid, bus.out_data, bus.out_idx} !== {1'b1, exp_neg, 4'd1}) begin
      errors++;
      $display("FAIL sat_min valid=%b data=%h idx=%0d exp 1 %h 1",
               bus.out_valid, bus.out_data, bus.out_idx, exp_neg);
    end
    tick();
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL sat_end valid got %b exp 0", bus.out_valid);
    end
  endtask

  task automatic test_backpressure();
    logic       rdy [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [7:0] edat[5] = '{8'd2, 8'd3, 8'd3, 8'd3, 8'd4};
    logic [3:0] eidx[5] = '{4'd0, 4'd1, 4'd1, 4'd1, 4'd2};
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1; bus.in_data = 20'd512; tick();
    bus.in_data = 20'd768; tick();
    bus.in_data = 20'd1024; tick();
    bus.in_valid = 1'b0; tick();
    for (int i = 0; i < 5; i++) begin
      bus.out_ready = rdy[i];
      checks++;
      if ({bus.out_valid, bus.out_data, bus.out_idx} !== {1'b1, edat[i], eidx[i]}) begin
        errors++;
        $display("FAIL bp_out step=%0d valid=%b data=%0d idx=%0d exp 1 %0d %0d",
                 i, bus.out_valid, bus.out_data, bus.out_idx, edat[i], eidx[i]);
      end
      tick();
    end
    checks++;
    if ({bus.out_valid, busy} !== 2'b00) begin
      errors++;
      $display("FAIL bp_end valid/busy got %b exp 00", {bus.out_valid, busy});
    end
  endtask

  task automatic test_overflow();
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1; bus.in_data = 20'd256; tick();
    bus.in_data = 20'd1280; tick();
    bus.in_valid = 1'b0; tick();
    bus.in_valid = 1'b1; bus.in_data = 20'h01000; tick();
    bus.in_valid = 1'b0;
    checks++;
    if ({overflow, bus.out_valid, bus.out_data, bus.out_idx} !== {2'b11, 8'd1, 4'd0}) begin
      errors++;
      $display("FAIL ovf_set ovf=%b valid=%b data=%0d idx=%0d exp 1 1 1 0",
               overflow, bus.out_valid, bus.out_data, bus.out_idx);
    end
    bus.out_ready = 1'b1;
    tick();
    checks++;
    if ({bus.out_valid, bus.out_data, bus.out_idx} !== {1'b1, 8'd5, 4'd1}) begin
      errors++;
      $display("FAIL ovf_second valid=%b data=%0d idx=%0d exp 1 5 1",
               bus.out_valid, bus.out_data, bus.out_idx);
    end
    tick();
    bus.out_ready = 1'b0;
    checks++;
    if ({bus.out_valid, overflow} !== 2'b01) begin
      errors++;
      $display("FAIL ovf_sticky valid/ovf got %b exp 01", {bus.out_valid, overflow});
    end
    sync_reset = 1'b1; tick();
    sync_reset = 1'b0;
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL ovf_clear ovf got %b exp 0", overflow);
    end
  endtask

  task automatic test_sync_reset_handshake();
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1; bus.in_data = 20'd256; tick();
    bus.in_data = 20'd512; tick();
    bus.in_data = 20'd768; tick();
    bus.in_valid = 1'b0; tick();
    bus.out_ready = 1'b1; tick();
    sync_reset = 1'b1; tick();
    sync_reset = 1'b0; bus.out_ready = 1'b0;
    checks++;
    if ({bus.out_valid, busy, bus.out_idx} !== 6'b0) begin
      errors++;
      $display("FAIL sync_rst valid/busy/idx got %b exp 000000",
               {bus.out_valid, busy, bus.out_idx});
    end
  endtask

  task automatic test_mode_gating();
    mode = 2'b01; bus.out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      bus.in_valid = 1'b1; bus.in_data = 20'(256 * (k + 1));
      tick();
      checks++;
      if ({bus.out_valid, busy, overflow} !== 3'b000) begin
        errors++;
        $display("FAIL mode_gate k=%0d valid/busy/ovf got %b exp 000",
                 k, {bus.out_valid, busy, overflow});
      end
    end
    bus.in_valid = 1'b0; mode = 2'b00;
    tick();
  endtask

  task automatic test_reset_mid();
    logic [7:0] exp_d;
    bus.out_ready = 1'b0;
    for (int k = 0; k < 7; k++) begin
      bus.in_valid = 1'b1; bus.in_data = 20'(300 * k);
      tick();
    end
    bus.in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({bus.out_valid, busy, overflow, bus.out_idx} !== 7'b0) begin
      errors++;
      $display("FAIL async_rst valid/busy/ovf/idx got %b exp 0000000",
               {bus.out_valid, busy, overflow, bus.out_idx});
    end
    #2 rst = 1'b0;
    tick();
    for (int k = 0; k < 16; k++) begin
      bus.in_valid = 1'b1; bus.in_data = 20'(-256 * k);
      tick();
    end
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
`ifdef COL_DRAIN_RELU_EN
      exp_d = 8'd0;
`else
      exp_d = 8'(-k);
`endif
      checks++;
      if ({bus.out_valid, bus.out_data, bus.out_idx} !== {1'b1, exp_d, 4'(k)}) begin
        errors++;
        $display("FAIL post_rst k=%0d valid=%b data=%h idx=%0d exp 1 %h %0d",
                 k, bus.out_valid, bus.out_data, bus.out_idx, exp_d, k);
      end
      tick();
    end
    checks++;
    if ({bus.out_valid, busy} !== 2'b00) begin
      errors++;
      $display("FAIL post_rst_end valid/busy got %b exp 00", {bus.out_valid, busy});
    end
  endtask

  initial begin
    test_reset();
    test_full_burst();
    test_saturation();
    test_backpressure();
    test_overflow();
    test_sync_reset_handshake();
    test_mode_gating();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
